uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter CNT_W, default 16, width of per-requester sent-byte counters.
REQ-002 Parameter FIFO_DEPTH, default 4, requester-0 FIFO entries; power of two, used only when UART_ARB_FIFO_EN is defined.
REQ-003 sysclk  input  1  single clock; all state updates on its rising edge.
REQ-004 cpu_resetn  input  1  asynchronous active-low reset.
REQ-005 req0_valid  input  1  requester 0 (CPU MMIO store) offers a byte.
REQ-006 req0_data  input  8  requester 0 byte.
REQ-007 req0_ready  output  1  requester 0 byte accepted this cycle when high with req0_valid.
REQ-008 req1_valid  input  1  requester 1 (boot/debug status) offers a byte.
REQ-009 req1_data  input  8  requester 1 byte.
REQ-010 req1_ready  output  1  requester 1 byte accepted this cycle when high with req1_valid.
REQ-011 tx_data  output  8  byte to UART serializer, stable from tx_start until tx_busy falls.
REQ-012 tx_start  output  1  one-cycle start pulse to serializer.
REQ-013 tx_busy  input  1  serializer busy; rises the cycle after tx_start, falls after stop bit.
REQ-014 grant_id  output  1  requester owning the byte in flight.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 cnt0, cnt1  output  CNT_W each  bytes completed per requester.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT_DONE.
REQ-018 IDLE: ready asserted combinationally only to the selected requester; selection = sole valid requester, or, if both valid, the one indicated by round-robin pointer rr.
REQ-019 Handshake: byte transferred when valid&&ready; data latched into tx_data, grant_id set, next state ISSUE.
REQ-020 Requester SHALL hold valid and data until ready; arbiter never asserts both readies in one cycle and never asserts ready outside IDLE.
REQ-021 ISSUE: if tx_busy==0, pulse tx_start for exactly one cycle, go WAIT_DONE; else stay ISSUE, tx_start low.
REQ-022 WAIT_DONE: ignore the first cycle after tx_start; then on tx_busy==0 go IDLE, increment cnt[grant_id], set rr to the other requester.
REQ-023 Latency: accept at cycle N, tx_start at N+1 when serializer idle; next accept no earlier than the cycle after tx_busy falls.
REQ-024 Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...
REQ-025 Counters wrap from 2^CNT_W-1 to 0 with no flag.
REQ-026 Valid deasserted by a requester before ready is a protocol violation; arbiter re-evaluates each IDLE cycle, no byte latched.

Reset
REQ-027 cpu_resetn low SHALL immediately force: state IDLE, rr=0, tx_start=0, tx_data=0, grant_id=0, busy=0, cnt0=cnt1=0, FIFO empty.
REQ-028 Reset mid-transfer SHALL abandon the in-flight byte without incrementing counters; readies low while reset asserted.
REQ-029 Reset deassertion SHALL be usable directly; first accept possible on the first rising edge after release.

Configuration
REQ-030 Macro UART_ARB_FIFO_EN: when defined, req0 path passes through a FIFO_DEPTH-entry FIFO; req0_ready = FIFO not full, independent of FSM state; arbiter treats FIFO non-empty as requester-0 valid and pops on grant.
REQ-031 FIFO simultaneous push and pop when full SHALL be refused (ready low); when empty, push-then-pop takes effect next cycle (no bypass).
REQ-032 Without UART_ARB_FIFO_EN, req0 is connected directly with the REQ-018..020 handshake; FIFO_DEPTH unused.

Verification
REQ-033 Reset low mid-WAIT_DONE -> all outputs at REQ-027 values same cycle, cnt0 unchanged at 0.
REQ-034 req0 only, data 0x41, serializer busy 10 cycles -> req0_ready at N, tx_start N+1 with tx_data 0x41, cnt0=1, busy low after tx_busy falls.
REQ-035 Both valid continuously, bytes 0xA0.. and 0xB0.. -> tx_data sequence A0,B0,A1,B1; cnt0=cnt1=2.
REQ-036 tx_busy held high at ISSUE entry for 5 cycles -> tx_start delayed until tx_busy low, exactly one pulse.
REQ-037 CNT_W=4, 17 req1 bytes -> cnt1 wraps to 1.
REQ-038 UART_ARB_FIFO_EN, FIFO_DEPTH=4, 6 back-to-back req0 bytes during transfer -> 4 accepted, req0_ready low until a pop, all bytes sent in order.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the two byte requesters / UART serializer and
// the uart_tx_arbiter. "slave" is the arbiter side, "master" is the
// environment side (requesters plus serializer).
interface uart_tx_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, tx_busy,
    output req0_ready, req1_ready, tx_data, tx_start
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, tx_busy,
    input  req0_ready, req1_ready, tx_data, tx_start
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-requester byte arbiter in front of a UART serializer.
// Requester 0 is the CPU MMIO path, requester 1 the boot/debug status path.
// Round-robin between simultaneous requesters, one byte in flight at a time,
// per-requester completed-byte counters (wrap silently).
// Optional feature: define UART_ARB_FIFO_EN to put a FIFO_DEPTH-entry FIFO
// (power of two, >= 2) on the requester-0 path.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE      | no byte held; ready offered to the selected requester
//   ISSUE     | byte latched; waiting for serializer idle to pulse tx_start
//   WAIT_DONE | byte handed off; waiting for tx_busy to fall
module uart_tx_arbiter #(
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             sysclk,
  input  logic             cpu_resetn,
  uart_tx_arbiter_if.slave bus,
  output logic             grant_id,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             grant_q, grant_d;
  logic             rr_q, rr_d;
  logic             wait_first_q, wait_first_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic             tx_start_c;

  logic             src0_valid;
  logic [7:0]       src0_data;
  logic             sel;
  logic             take0;
  logic             take1;

`ifdef UART_ARB_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] FILL_FULL = FW'(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          push;

  // Ready depends only on fullness, so a pop in the same cycle never frees a slot early.
  assign bus.req0_ready = cpu_resetn && (fill_q != FILL_FULL);
  assign push           = bus.req0_valid && bus.req0_ready;
  assign src0_valid     = (fill_q != '0);
  assign src0_data      = mem_q[rd_q];
  assign bus.req1_ready = take1;

  // FIFO bookkeeping: push from requester 0, pop when the arbiter grants it.
  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    if (push) begin
      mem_d[wr_q] = bus.req0_data;
      wr_d        = wr_q + 1'b1;
    end
    if (take0) begin
      rd_d = rd_q + 1'b1;
    end
    fill_d = fill_q + FW'(push) - FW'(take0);
  end

  // FIFO storage and pointers; reset empties the FIFO.
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fill_q <= fill_d;
    end
  end
`else
  logic unused_fifo_depth;

  assign unused_fifo_depth = (FIFO_DEPTH == 0);
  assign src0_valid        = bus.req0_valid;
  assign src0_data         = bus.req0_data;
  assign bus.req0_ready    = take0;
  assign bus.req1_ready    = take1;
`endif

  // Requester selection: sole valid requester wins, ties go to the rr pointer.
  always_comb begin
    sel   = 1'b0;
    take0 = 1'b0;
    take1 = 1'b0;
    if (src0_valid && bus.req1_valid) begin
      sel = rr_q;
    end else if (!src0_valid) begin
      sel = 1'b1;
    end
    if (cpu_resetn && (state_q == IDLE)) begin
      take0 = src0_valid && !sel;
      take1 = bus.req1_valid && sel;
    end
  end

  // Next-state and datapath updates for the byte in flight.
  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    grant_d      = grant_q;
    rr_d         = rr_q;
    wait_first_d = wait_first_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    tx_start_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (take0) begin
          tx_data_d = src0_data;
          grant_d   = 1'b0;
          state_d   = ISSUE;
        end else if (take1) begin
          tx_data_d = bus.req1_data;
          grant_d   = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.tx_busy) begin
          tx_start_c   = 1'b1;
          wait_first_d = 1'b1;
          state_d      = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // tx_busy only rises the cycle after tx_start, so skip that cycle.
        if (wait_first_q) begin
          wait_first_d = 1'b0;
        end else if (!bus.tx_busy) begin
          state_d = IDLE;
          rr_d    = ~grant_q;
          if (grant_q) begin
            cnt1_d = cnt1_q + CNT_W'(1);
          end else begin
            cnt0_d = cnt0_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any byte in flight.
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state_q      <= IDLE;
      tx_data_q    <= '0;
      grant_q      <= 1'b0;
      rr_q         <= 1'b0;
      wait_first_q <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      grant_q      <= grant_d;
      rr_q         <= rr_d;
      wait_first_q <= wait_first_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_c;
  assign grant_id     = grant_q;
  assign busy         = (state_q != IDLE);
  assign cnt0         = cnt0_q;
  assign cnt1         = cnt1_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a random
// phase, all compared every cycle against a byte-lifecycle model.
module tb_uart_tx_arbiter;
  localparam int CNT_W = 4;
  localparam int DEPTH = 4;
  localparam int CMOD  = 1 << CNT_W;

  localparam int B_NONE = 0;  // no byte owned by the arbiter
  localparam int B_HELD = 1;  // byte accepted, not yet launched
  localparam int B_SENT = 2;  // byte launched, serializer working

  logic sysclk = 1'b0;
  logic cpu_resetn = 1'b0;
  logic grant_id, busy;
  logic [CNT_W-1:0] cnt0, cnt1;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)) dut (
    .sysclk    (sysclk),
    .cpu_resetn(cpu_resetn),
    .bus       (bus),
    .grant_id  (grant_id),
    .busy      (busy),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
  );

  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- serializer model ----------------
  int   ser_len = 3;
  int   ser_left = 0;
  logic ser_busy = 1'b0;
  logic ext_busy = 1'b0;
  logic start_seen;

  assign bus.tx_busy = ser_busy | ext_busy;

  initial begin : serializer
    forever begin
      @(negedge sysclk);
      start_seen = bus.tx_start;
      @(posedge sysclk);
      #1;
      if (!cpu_resetn) ser_left = 0;
      else if (start_seen) ser_left = ser_len;
      else if (ser_left > 0) ser_left--;
      ser_busy = (ser_left > 0);
    end
  end

  // ---------------- requester drivers ----------------
  int         en[2]   = '{0, 0};
  int         lim[2]  = '{0, 0};
  int         sent[2] = '{0, 0};
  int         pct[2]  = '{100, 100};
  int         wd_pct  = 0;
  logic [7:0] base[2] = '{8'h00, 8'h00};
  bit         seqd[2] = '{1'b1, 1'b1};

  function automatic logic [7:0] pick(int k);
    if (seqd[k]) return 8'(int'(base[k]) + sent[k]);
    return 8'($urandom);
  endfunction

  initial begin : driver
    logic h0, h1;
    bus.req0_valid = 1'b0;
    bus.req0_data  = 8'h00;
    bus.req1_valid = 1'b0;
    bus.req1_data  = 8'h00;
    forever begin
      @(negedge sysclk);
      h0 = bus.req0_valid && bus.req0_ready;
      h1 = bus.req1_valid && bus.req1_ready;
      @(posedge sysclk);
      #1;
      if (h0) sent[0]++;
      if (h1) sent[1]++;
      if (en[0] == 0 || sent[0] >= lim[0]) bus.req0_valid = 1'b0;
      else if (h0 || !bus.req0_valid) begin
        bus.req0_valid = ($urandom_range(99) < pct[0]);
        if (bus.req0_valid) bus.req0_data = pick(0);
      end else if ($urandom_range(99) < wd_pct) bus.req0_valid = 1'b0;
      if (en[1] == 0 || sent[1] >= lim[1]) bus.req1_valid = 1'b0;
      else if (h1 || !bus.req1_valid) begin
        bus.req1_valid = ($urandom_range(99) < pct[1]);
        if (bus.req1_valid) bus.req1_data = pick(1);
      end else if ($urandom_range(99) < wd_pct) bus.req1_valid = 1'b0;
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  int         st = B_NONE;
  int         age = 0;
  logic [7:0] m_data = 8'h00;
  logic       m_id = 1'b0;
  logic       m_rr = 1'b0;
  int         m_cnt[2] = '{0, 0};
  logic [7:0] fq[$];
  logic [7:0] log_q[$];

  initial begin : compare
    logic v0, v1, g0, e_r0, e_r1, e_start;
    forever begin
      @(negedge sysclk);
      if (!cpu_resetn) begin
        st = B_NONE; age = 0; m_rr = 1'b0; m_cnt = '{0, 0}; fq.delete();
        check("rst_req0_ready", bus.req0_ready, 0);
        check("rst_req1_ready", bus.req1_ready, 0);
        check("rst_tx_start", bus.tx_start, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt0", cnt0, 0);
        check("rst_cnt1", cnt1, 0);
      end else begin
`ifdef UART_ARB_FIFO_EN
        v0 = (fq.size() > 0);
`else
        v0 = bus.req0_valid;
`endif
        v1 = bus.req1_valid;
        g0   = (st == B_NONE) && v0 && (!v1 || !m_rr);
        e_r1 = (st == B_NONE) && v1 && (!v0 || m_rr);
`ifdef UART_ARB_FIFO_EN
        e_r0 = (fq.size() < DEPTH);
`else
        e_r0 = g0;
`endif
        e_start = (st == B_HELD) && !bus.tx_busy;
        check("req0_ready", bus.req0_ready, e_r0);
        check("req1_ready", bus.req1_ready, e_r1);
        check("tx_start", bus.tx_start, e_start);
        check("busy", busy, st != B_NONE);
        check("cnt0", cnt0, m_cnt[0]);
        check("cnt1", cnt1, m_cnt[1]);
        if (st != B_NONE) begin
          check("tx_data", bus.tx_data, m_data);
          check("grant_id", grant_id, m_id);
        end
        if (bus.tx_start) log_q.push_back(bus.tx_data);
        // advance the byte lifecycle across the coming edge
        case (st)
          B_NONE: begin
            if (g0) begin
              m_id = 1'b0;
`ifdef UART_ARB_FIFO_EN
              m_data = fq.pop_front();
`else
              m_data = bus.req0_data;
`endif
              st = B_HELD;
            end else if (e_r1) begin
              m_id = 1'b1; m_data = bus.req1_data; st = B_HELD;
            end
          end
          B_HELD: if (!bus.tx_busy) begin st = B_SENT; age = 0; end
          default: begin
            if (age == 0) age = 1;
            else if (!bus.tx_busy) begin
              m_cnt[m_id] = (m_cnt[m_id] + 1) % CMOD;
              m_rr = !m_id;
              st = B_NONE;
            end
          end
        endcase
`ifdef UART_ARB_FIFO_EN
        if (bus.req0_valid && e_r0) fq.push_back(bus.req0_data);
`endif
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic do_reset();
    @(posedge sysclk); #2;
    cpu_resetn = 1'b0;
    en = '{0, 0}; wd_pct = 0; ext_busy = 1'b0; pct = '{100, 100}; seqd = '{1'b1, 1'b1};
    repeat (2) @(posedge sysclk);
    #2;
    sent = '{0, 0};
    log_q.delete();
    cpu_resetn = 1'b1;
  endtask

  initial begin : stim
    int ok, nb, early, pulses;
    logic [7:0] seen;
    logic [7:0] exp_c[4];

    // reset state
    repeat (3) @(negedge sysclk);
    check("a_rst_busy", busy, 0);
    check("a_rst_ready1", bus.req1_ready, 0);
    @(posedge sysclk); #2;
    cpu_resetn = 1'b1;

    // single req0 byte 0x41, 10-cycle serializer
    do_reset();
    ser_len = 10; base[0] = 8'h41; lim[0] = 1; en[0] = 1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sysclk);
      if (bus.req0_valid && bus.req0_ready) begin ok = 1; break; end
    end
    check("t34_accept", ok, 1);
    @(negedge sysclk);
    check("t34_start", bus.tx_start, 1);
    check("t34_data", bus.tx_data, 8'h41);
    nb = 1; ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge sysclk);
      if (!busy) begin ok = 1; break; end
      nb++;
    end
    check("t34_done", ok, 1);
    check("t34_busy_len", nb, 12);
    check("t34_cnt0", cnt0, 1);
    check("t34_tx_busy", bus.tx_busy, 0);

    // both requesters continuously valid: strict alternation
    do_reset();
    ser_len = 3; base = '{8'hA0, 8'hB0}; lim = '{2, 2}; en = '{1, 1};
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sysclk);
      if (sent[0] == 2 && sent[1] == 2 && !busy) begin ok = 1; break; end
    end
    check("t35_done", ok, 1);
    exp_c = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
    check("t35_len", log_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check("t35_seq", (i < log_q.size()) ? 32'(log_q[i]) : 32'hFFFF, exp_c[i]);
    check("t35_cnt0", cnt0, 2);
    check("t35_cnt1", cnt1, 2);

    // serializer held busy at ISSUE entry for 5 cycles
    do_reset();
    ser_len = 3; ext_busy = 1'b1; base[1] = 8'h5C; lim[1] = 1; en[1] = 1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sysclk);
      if (bus.req1_valid && bus.req1_ready) begin ok = 1; break; end
    end
    check("t36_accept", ok, 1);
    early = 0;
    repeat (5) begin
      @(negedge sysclk);
      if (bus.tx_start) early++;
    end
    @(posedge sysclk); #2;
    ext_busy = 1'b0;
    pulses = 0; seen = 8'h00;
    repeat (20) begin
      @(negedge sysclk);
      if (bus.tx_start) begin pulses++; seen = bus.tx_data; end
    end
    check("t36_early", early, 0);
    check("t36_pulses", pulses, 1);
    check("t36_data", seen, 8'h5C);

    // counter wrap: 17 req1 bytes with 4-bit counters
    do_reset();
    ser_len = 1; base[1] = 8'h00; lim[1] = 17; en[1] = 1;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge sysclk);
      if (sent[1] == 17 && !busy) begin ok = 1; break; end
    end
    check("t37_done", ok, 1);
    check("t37_cnt1", cnt1, 1);
    check("t37_cnt0", cnt0, 0);

    // reset mid-WAIT_DONE abandons the byte
    do_reset();
    ser_len = 10; base[0] = 8'h33; lim[0] = 1; en[0] = 1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sysclk);
      if (bus.tx_start) begin ok = 1; break; end
    end
    check("t33_start", ok, 1);
    repeat (3) @(negedge sysclk);
    @(posedge sysclk); #2;
    cpu_resetn = 1'b0;
    #1;
    check("t33_tx_data", bus.tx_data, 0);
    check("t33_busy", busy, 0);
    check("t33_tx_start", bus.tx_start, 0);
    check("t33_grant", grant_id, 0);
    check("t33_cnt0", cnt0, 0);
    check("t33_ready0", bus.req0_ready, 0);
    @(posedge sysclk); #2;
    cpu_resetn = 1'b1;
    repeat (15) @(negedge sysclk);
    check("t33_after_cnt0", cnt0, 0);
    check("t33_after_busy", busy, 0);

`ifdef UART_ARB_FIFO_EN
    // FIFO fills to depth while the arbiter is occupied
    do_reset();
    ser_len = 20; base[1] = 8'h77; lim[1] = 1; en[1] = 1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sysclk);
      if (bus.tx_start) begin ok = 1; break; end
    end
    check("t38_b_start", ok, 1);
    @(posedge sysclk); #2;
    base[0] = 8'h10; lim[0] = 6; en[0] = 1;
    repeat (10) @(negedge sysclk);
    check("t38_accepted", sent[0], 4);
    check("t38_ready_low", bus.req0_ready, 0);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge sysclk);
      if (sent[0] == 6 && !busy && !bus.req0_valid) begin ok = 1; break; end
    end
    repeat (20) @(negedge sysclk);
    check("t38_done", ok, 1);
    check("t38_len", log_q.size(), 7);
    for (int i = 0; i < 6; i++)
      check("t38_order", (i + 1 < log_q.size()) ? 32'(log_q[i+1]) : 32'hFFFF, 32'h10 + i);
`endif

    // random traffic
    do_reset();
    seqd = '{1'b0, 1'b0}; pct = '{40, 60}; wd_pct = 3;
    lim = '{1000000, 1000000}; en = '{1, 1};
    for (int c = 0; c < 3000; c++) begin
      @(posedge sysclk); #2;
      if ($urandom_range(49) == 0) ser_len = int'($urandom_range(6, 1));
      ext_busy = ($urandom_range(99) < 6);
      if ($urandom_range(599) == 0) begin
        cpu_resetn = 1'b0;
        @(posedge sysclk); #2;
        cpu_resetn = 1'b1;
      end
    end
    @(posedge sysclk); #2;
    en = '{0, 0}; ext_busy = 1'b0;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sysclk);
      if (!busy) begin ok = 1; break; end
    end
    repeat (40) @(negedge sysclk);
    check("rand_drain", ok, 1);
    check("rand_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
